hid_report_collector: RTL and testbench
=======================================

Name: hid_report_collector

Overview:
Parametrised N-channel collector for USB HID host report streams. It replaces per-host ad-hoc report latching in the top level. Each channel's latest report is latched and exposed as one flat display vector. The block tracks per-channel liveness with a timeout and queues changed reports to a single round-robin valid/ready output for downstream consumers (hex display, game logic). It sits between the usbh_host_hid instances and the pixel/consumer logic, all in the USB clock domain.

Parameters:
C_channels, 2, number of HID host channels (1..8)
C_report_bytes, 8, bytes per input report
C_disp_bytes, 8, low bytes per channel copied to o_display (1..C_report_bytes)
C_timeout, 6000000, cycles without in_valid before a channel is declared dead (>=2)
C_clear_on_timeout, 1, 1: stored report zeroed on timeout; 0: retained

Ports:
clk_i  in  1  clock (USB clock, 6 or 48 MHz)
rstn_i  in  1  asynchronous active-low reset
in_report  in  C_channels*C_report_bytes*8  channel k occupies slice [k*R*8 +: R*8], R=C_report_bytes
in_valid  in  C_channels  one-cycle strobe per channel, report valid this cycle
o_display  out  C_channels*C_disp_bytes*8  low C_disp_bytes of each stored report, channel k at [k*D*8 +: D*8]
o_alive  out  C_channels  channel received a report within last C_timeout cycles
o_overrun  out  C_channels  sticky: pending change overwritten before emission
clr_overrun  in  C_channels  clears matching o_overrun bits
out_report  out  C_report_bytes*8  emitted report
out_chan  out  CW  channel index of out_report, CW=max(1,$clog2(C_channels))
out_valid  out  1  output holds a report
out_ready  in  1  consumer accepts when out_valid&out_ready

Behaviour:
- Async reset: stored reports, o_display, out_report, out_chan = 0; o_alive, o_overrun, pending, out_valid = 0; timeout counters = 0; round-robin pointer = C_channels-1, so channel 0 has priority first.
- Capture: in_valid[k] at edge N -> stored[k] updated at N+1 and o_display updated at N+1. Timeout counter k reset to 0 and o_alive[k]=1 at N+1. pending[k] is set only if the new report differs from stored[k].
- Overrun: if pending[k] is already set and a differing report arrives, o_overrun[k] is set. The newer data replaces the older.
- Timeout: counter k increments while o_alive[k] and no in_valid[k]. On reaching C_timeout-1, the following edge clears o_alive[k].
  - If C_clear_on_timeout=1 and stored[k]!=0: stored[k] is zeroed and pending[k] is set (emits a release report).
  - Counters saturate; a dead channel's counter does not run.
- Output FSM, states IDLE and HOLD:
  - IDLE: if any pending, select the first pending channel strictly after the pointer, wrapping modulo C_channels. Load out_report=stored[sel] and out_chan=sel, set out_valid, clear pending[sel], pointer=sel, go to HOLD.
  - HOLD: out_report and out_chan are stable. On out_valid&out_ready, out_valid drops the next cycle and the FSM returns to IDLE. No back-to-back emission; max throughput is one report per 2 cycles.
- Earliest latency: in_valid at edge N -> out_valid at N+2.
- Simultaneous events:
  - New differing report on channel sel in the same cycle the FSM loads sel: pending[sel] remains set (set wins over clear). The load uses the pre-update stored value.
  - in_valid and timeout in the same cycle: in_valid wins.
  - clr_overrun and a new overrun in the same cycle: set wins.
- Reset mid-HOLD: out_valid drops immediately (async). Consumers must treat this as transaction abort.
- Stored data updates never alter out_report while in HOLD.

Decomposition:
- Package hid_collector_pkg holds the CW calculation function and byte-slice width constants.
- Sub-module hid_rr_arbiter (C_channels) is natural. Inputs: pending vector and pointer. Outputs: one-hot/index grant plus a grant-valid signal, purely combinational.
- Per-channel storage, compare and timeout live in a generate loop in the top module.

Test Plan:
- Single capture: ch0 in_valid with report 0x0102030405060708 -> o_display[63:0]=0x0102030405060708 at N+1; out_valid at N+2 with out_chan=0. With out_ready=1, one handshake, then out_valid=0.
- Duplicate suppression: ch1 sends the same report 0x55 twice, 100 cycles apart -> exactly one emission; o_alive[1]=1 throughout.
- Round-robin fairness: channels 0 and 1 both become pending in the same cycle with out_ready=1 -> emission order ch0, ch1. A repeat of the same pattern yields ch0, ch1 again after the pointer wraps.
- Backpressure and overrun: out_ready=0, ch0 emitting; ch1 sends 0xAA then 0xBB -> o_overrun[1]=1. After release, ch1 emits 0xBB; clr_overrun[1] clears the flag.
- Timeout (C_timeout=16): ch0 sends 0x11 then goes silent -> o_alive[0] falls 16 cycles after the last capture edge. A zero report is emitted on ch0 and o_display channel 0 reads 0.
- Async reset asserted during HOLD -> out_valid, o_alive, o_display all 0 immediately. After release, the first pending grant goes to ch0.

Source files
------------

// File: rtl/hid_collector_pkg.sv
// Shared sizing helpers for the HID report collector and its arbiter.
package hid_collector_pkg;

  localparam int C_BYTE_W = 8;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int calc_cw(input int n);
    if (n <= 1) return 1;
    else return $clog2(n);
  endfunction

  function automatic int bytes_to_bits(input int n_bytes);
    return n_bytes * C_BYTE_W;
  endfunction

endpackage

// File: rtl/hid_rr_arbiter.sv
// Combinational round-robin pick: first pending channel strictly after ptr,
// wrapping modulo C_channels.
module hid_rr_arbiter
  import hid_collector_pkg::*;
#(
  parameter int C_channels = 2,
  localparam int CW = calc_cw(C_channels)
) (
  input  logic [C_channels-1:0] pending,
  input  logic [CW-1:0]         ptr,
  output logic [C_channels-1:0] grant_onehot,
  output logic [CW-1:0]         grant_idx,
  output logic                  grant_valid
);

  int best;
  int best_d;
  int d;

  // Rank each pending channel by its distance past the pointer; closest wins.
  always_comb begin
    best         = 0;
    best_d       = C_channels;
    d            = 0;
    grant_valid  = 1'b0;
    grant_onehot = '0;
    for (int j = 0; j < C_channels; j++) begin
      d = (j - int'(ptr) - 1 + 2 * C_channels) % C_channels;
      if (pending[j] && (d < best_d)) begin
        best_d = d;
        best   = j;
      end
    end
    grant_valid = (best_d < C_channels);
    grant_idx   = CW'(best);
    for (int j = 0; j < C_channels; j++) begin
      grant_onehot[j] = grant_valid && (best == j);
    end
  end

endmodule

// File: rtl/hid_report_collector.sv
// Latches the latest report of each HID host channel, tracks per-channel
// liveness, and forwards changed reports one at a time on a valid/ready port.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no report presented; pick next pending channel round-robin
//   HOLD   | out_report/out_chan presented, waiting for out_ready
module hid_report_collector
  import hid_collector_pkg::*;
#(
  parameter int C_channels         = 2,
  parameter int C_report_bytes     = 8,
  parameter int C_disp_bytes       = 8,
  parameter int C_timeout          = 6000000,
  parameter int C_clear_on_timeout = 1,
  localparam int CW = calc_cw(C_channels)
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [C_channels*C_report_bytes*8-1:0] in_report,
  input  logic [C_channels-1:0]                 in_valid,
  output logic [C_channels*C_disp_bytes*8-1:0]  o_display,
  output logic [C_channels-1:0]                 o_alive,
  output logic [C_channels-1:0]                 o_overrun,
  input  logic [C_channels-1:0]                 clr_overrun,
  output logic [C_report_bytes*8-1:0]           out_report,
  output logic [CW-1:0]                         out_chan,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int RW = bytes_to_bits(C_report_bytes);
  localparam int DW = bytes_to_bits(C_disp_bytes);
  localparam int TW = $clog2(C_timeout);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]            state;
  logic [CW-1:0]         rr_ptr;
  logic [RW-1:0]         stored_q [C_channels];
  logic [C_channels-1:0] pending;
  logic [C_channels-1:0] grant_onehot;
  logic [CW-1:0]         grant_idx;
  logic                  grant_valid;
  logic                  load;

  assign load = (state == S_IDLE) && grant_valid;

  hid_rr_arbiter #(
    .C_channels (C_channels)
  ) u_arb (
    .pending      (pending),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  for (genvar g = 0; g < C_channels; g++) begin : g_chan
    logic [RW-1:0] stored_r;
    logic [RW-1:0] rpt_in;
    logic [TW-1:0] cnt;
    logic          alive_r;
    logic          pend_r;
    logic          ovr_r;
    logic          differs;
    logic          tmo;
    logic          pend_set;
    logic          pend_clr;
    logic          ovr_set;

    assign rpt_in  = in_report[g*RW +: RW];
    assign differs = (rpt_in != stored_r);
    assign tmo     = alive_r && !in_valid[g] && (cnt == TW'(C_timeout - 1));

    // A release report is only worth sending if the cleared data was non-zero.
    assign pend_set = (in_valid[g] && differs) ||
                      (tmo && (C_clear_on_timeout != 0) && (stored_r != '0));
    assign pend_clr = load && grant_onehot[g];
    // A change already being loaded this cycle was emitted, not overwritten.
    assign ovr_set  = in_valid[g] && differs && pend_r && !pend_clr;

    assign stored_q[g]               = stored_r;
    assign o_display[g*DW +: DW]     = stored_r[DW-1:0];
    assign o_alive[g]                = alive_r;
    assign o_overrun[g]              = ovr_r;
    assign pending[g]                = pend_r;

    // Per-channel capture, liveness timer, pending and overrun flags.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        stored_r <= '0;
        cnt      <= '0;
        alive_r  <= 1'b0;
        pend_r   <= 1'b0;
        ovr_r    <= 1'b0;
      end else begin
        if (in_valid[g]) begin
          stored_r <= rpt_in;
          cnt      <= '0;
          alive_r  <= 1'b1;
        end else if (alive_r) begin
          if (cnt == TW'(C_timeout - 1)) begin
            alive_r <= 1'b0;
            if (C_clear_on_timeout != 0) stored_r <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        pend_r <= pend_set | (pend_r & ~pend_clr);
        ovr_r  <= ovr_set | (ovr_r & ~clr_overrun[g]);
      end
    end
  end

  // Output FSM: load one report, hold it until accepted, then rest a cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_report <= '0;
      out_chan   <= '0;
      rr_ptr     <= CW'(C_channels - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            out_report <= stored_q[grant_idx];
            out_chan   <= grant_idx;
            out_valid  <= 1'b1;
            rr_ptr     <= grant_idx;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hid_report_collector.sv
// Bench for hid_report_collector: table-driven captures, a scoreboard for
// emitted reports, and hand-written sequences for the multi-cycle cases.
module tb_hid_report_collector;

  localparam int NC = 2;
  localparam int RW = 64;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rstn_i;
  logic [NC*RW-1:0]  in_report;
  logic [NC-1:0]     in_valid;
  logic [NC-1:0]     clr_overrun;
  logic              out_ready;

  logic [NC*RW-1:0]  disp,   disp_t;
  logic [NC-1:0]     alive,  alive_t;
  logic [NC-1:0]     ovr,    ovr_t;
  logic [RW-1:0]     orpt,   orpt_t;
  logic              ochan,  ochan_t;
  logic              ovalid, ovalid_t;

  hid_report_collector #(
    .C_channels(NC), .C_report_bytes(8), .C_disp_bytes(8),
    .C_timeout(1000), .C_clear_on_timeout(1)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .in_report(in_report), .in_valid(in_valid),
    .o_display(disp), .o_alive(alive), .o_overrun(ovr), .clr_overrun(clr_overrun),
    .out_report(orpt), .out_chan(ochan), .out_valid(ovalid), .out_ready(out_ready)
  );

  hid_report_collector #(
    .C_channels(NC), .C_report_bytes(8), .C_disp_bytes(8),
    .C_timeout(16), .C_clear_on_timeout(1)
  ) dut_t (
    .clk_i(clk_i), .rstn_i(rstn_i), .in_report(in_report), .in_valid(in_valid),
    .o_display(disp_t), .o_alive(alive_t), .o_overrun(ovr_t), .clr_overrun(clr_overrun),
    .out_report(orpt_t), .out_chan(ochan_t), .out_valid(ovalid_t), .out_ready(out_ready)
  );

  typedef struct {
    int          chan;
    logic [63:0] rpt;
    int          gap;
    bit          exp_emit;
  } vec_t;

  typedef struct {
    int          chan;
    logic [63:0] rpt;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int ch, input logic [63:0] r);
    exp_t e;
    e.chan = ch;
    e.rpt  = r;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rstn_i      = 1'b0;
    in_valid    = '0;
    clr_overrun = '0;
    in_report   = '0;
    repeat (2) tick();
    rstn_i = 1'b1;
    tick();
    sb.delete();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || ovalid) && k < 60) begin
      tick();
      k++;
    end
    check(name, (sb.size() == 0 && !ovalid), 1'b1);
  endtask

  // Scoreboard: each accepted handshake on the main DUT must match the queue head.
  always @(negedge clk_i) begin
    exp_t e;
    if (rstn_i === 1'b1 && ovalid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_emit: chan %0d report %0h, expected no emission", ochan, orpt);
      end else begin
        e = sb.pop_front();
        check("emit_chan", ochan, e.chan);
        check("emit_report", orpt, e.rpt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{chan: 0, rpt: 64'h0102030405060708, gap: 0,   exp_emit: 1'b1};
    vecs[1] = '{chan: 1, rpt: 64'h55,               gap: 100, exp_emit: 1'b1};
    vecs[2] = '{chan: 1, rpt: 64'h55,               gap: 0,   exp_emit: 1'b0};
    vecs[3] = '{chan: 0, rpt: 64'h0102030405060708, gap: 0,   exp_emit: 1'b0};
    vecs[4] = '{chan: 0, rpt: 64'hDEADBEEFCAFEF00D, gap: 0,   exp_emit: 1'b1};
    vecs[5] = '{chan: 1, rpt: 64'h0,                gap: 0,   exp_emit: 1'b1};
    vecs[6] = '{chan: 0, rpt: 64'hFFFFFFFFFFFFFFFF, gap: 0,   exp_emit: 1'b1};

    out_ready = 1'b1;
    do_reset();

    check("rst_out_valid", ovalid, 1'b0);
    check("rst_alive", alive, 2'b00);
    check("rst_overrun", ovr, 2'b00);
    check("rst_display", disp, 128'h0);
    check("rst_out_report", orpt, 64'h0);

    // Table: capture, display, emission latency and duplicate suppression.
    for (int i = 0; i < 7; i++) begin
      int ch;
      ch = vecs[i].chan;
      in_report[ch*RW +: RW] = vecs[i].rpt;
      in_valid = '0;
      in_valid[ch] = 1'b1;
      if (vecs[i].exp_emit) push(ch, vecs[i].rpt);
      tick();
      in_valid = '0;
      check("tbl_display", disp[ch*RW +: RW], vecs[i].rpt);
      check("tbl_alive", alive[ch], 1'b1);
      tick();
      check("tbl_out_valid", ovalid, vecs[i].exp_emit);
      if (vecs[i].exp_emit) check("tbl_out_chan", ochan, ch[0]);
      tick();
      check("tbl_out_valid_drop", ovalid, 1'b0);
      for (int k = 0; k < vecs[i].gap; k++) tick();
      if (vecs[i].gap > 0) check("tbl_alive_gap", alive[ch], 1'b1);
    end
    drain("tbl_drain");

    // Round-robin: simultaneous pending on both channels, twice.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      logic [63:0] r0, r1;
      r0 = 64'hA0 + 64'(rep * 16);
      r1 = 64'hA1 + 64'(rep * 16);
      in_report = {r1, r0};
      in_valid  = 2'b11;
      push(0, r0);
      push(1, r1);
      tick();
      in_valid = '0;
      tick();
      check("rr_first_chan", ochan, 1'b0);
      drain("rr_drain");
    end

    // Backpressure, overrun, HOLD stability, overrun clear.
    do_reset();
    out_ready = 1'b0;
    in_report[0 +: RW] = 64'h01;
    in_valid = 2'b01;
    push(0, 64'h01);
    tick();
    in_valid = '0;
    tick();
    check("bp_hold_valid", ovalid, 1'b1);
    in_report[RW +: RW] = 64'hAA;
    in_valid = 2'b10;
    tick();
    in_report[RW +: RW] = 64'hBB;
    tick();
    in_report[0 +: RW] = 64'h02;
    in_valid = 2'b01;
    tick();
    in_valid = '0;
    tick();
    check("bp_overrun", ovr, 2'b10);
    check("bp_hold_report", orpt, 64'h01);
    check("bp_hold_chan", ochan, 1'b0);
    push(1, 64'hBB);
    push(0, 64'h02);
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_overrun_sticky", ovr, 2'b10);
    clr_overrun = 2'b10;
    tick();
    clr_overrun = '0;
    check("bp_overrun_clr", ovr, 2'b00);

    // Timeout on the short-timeout instance; main instance stays alive.
    do_reset();
    in_report[0 +: RW] = 64'h11;
    in_valid = 2'b01;
    push(0, 64'h11);
    tick();
    in_valid = '0;
    check("to_display_pre", disp_t[0 +: RW], 64'h11);
    check("to_alive_pre", alive_t[0], 1'b1);
    repeat (15) tick();
    check("to_alive_15", alive_t[0], 1'b1);
    tick();
    check("to_alive_16", alive_t[0], 1'b0);
    check("to_display_zero", disp_t[0 +: RW], 64'h0);
    tick();
    check("to_release_valid", ovalid_t, 1'b1);
    check("to_release_report", orpt_t, 64'h0);
    check("to_release_chan", ochan_t, 1'b0);
    drain("to_drain");
    check("to_main_alive", alive[0], 1'b1);

    // Reset in HOLD, then first grant after reset goes to ch0.
    out_ready = 1'b0;
    in_report[RW +: RW] = 64'h33;
    in_valid = 2'b10;
    tick();
    in_valid = '0;
    tick();
    check("rh_hold_valid", ovalid, 1'b1);
    #1 rstn_i = 1'b0;
    #1;
    check("rh_out_valid", ovalid, 1'b0);
    check("rh_alive", alive, 2'b00);
    check("rh_display", disp, 128'h0);
    sb.delete();
    tick();
    rstn_i    = 1'b1;
    out_ready = 1'b1;
    tick();
    in_report = {64'h45, 64'h44};
    in_valid  = 2'b11;
    push(0, 64'h44);
    push(1, 64'h45);
    tick();
    in_valid = '0;
    tick();
    check("rh_first_valid", ovalid, 1'b1);
    check("rh_first_chan", ochan, 1'b0);
    drain("rh_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
